// File: rtl/serial_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_seq_pkg
// Purpose : Shared types and helpers for the bit-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
package serial_add_seq_pkg;

    // Controller states: waiting for operands, shifting bits, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : serial_add_seq_pkg
`default_nettype wire

// File: rtl/serial_add_seq_fa_cell.sv
`default_nettype none
// ============================================================================
// Module  : fa_cell
// Purpose : Purely combinational 1-bit full adder used by the serial adder.
// Revision: 1.0 - initial release
// ============================================================================
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    // Propagate term shared by sum and carry.
    assign w_p = x ^ y;
    assign s   = w_p ^ ci;
    assign co  = (x & y) | (ci & w_p);

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : serial_add_seq
// Purpose : Bit-serial W-bit adder built on one full-adder cell. Operands are
//           accepted on a valid/ready handshake, summed LSB first over W
//           cycles, and the sum/carry-out offered on an output handshake.
// Revision: 1.0 - initial release
// ============================================================================
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    // Counter must hold 0..W without wrapping.
    localparam int             CNT_W    = clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       sa_q, sa_d;
    logic [W-1:0]       sb_q, sb_d;
    logic [W-1:0]       sr_q, sr_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_s;
    logic               fa_co;

    // The single full-adder cell always looks at the current LSBs and carry.
    fa_cell u_fa (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .ci (cy_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update: load in IDLE, shift in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    cy_d    = cin;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d       = sa_q >> 1;
                sb_d       = sb_q >> 1;
                // New sum bit enters at the MSB so after W shifts bit 0 is LSB.
                sr_d       = sr_q >> 1;
                sr_d[W-1]  = fa_s;
                cy_d       = fa_co;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so no input reaches them combinationally.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sr_q;
    assign cout      = cy_q;

endmodule : serial_add_seq
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_add_seq
// Purpose : Directed self-checking bench for serial_add_seq (W=8 and W=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

    logic       clk;
    logic       rst;

    // W = 8 instance signals
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    // W = 1 instance signals
    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;

    int errors;
    int checks;

    serial_add_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    serial_add_seq #(.W(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full W=8 transaction with out_ready high; returns on cycle W+2.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic [7:0] esum, input logic ecout);
        chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        tick();                                 // accept edge -> cycle 1
        in_valid = 1'b0;
        chk({tag, ".busy_c1"}, 32'(busy), 32'd1);
        repeat (7) tick();                      // cycle 8
        chk({tag, ".ov_c8"}, 32'(out_valid), 32'd0);
        tick();                                 // cycle 9
        chk({tag, ".ov_c9"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"}, 32'(sum), 32'(esum));
        chk({tag, ".cout"}, 32'(cout), 32'(ecout));
        chk({tag, ".in_ready_c9"}, 32'(in_ready), 32'd0);
        tick();                                 // cycle 10
        chk({tag, ".in_ready_c10"}, 32'(in_ready), 32'd1);
        chk({tag, ".ov_c10"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        out_ready1 = 1'b1;

        tick();
        tick();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.in_ready1", 32'(in_ready1), 32'd1);
        rst = 1'b0;
        tick();

        // Basic and carry-ripple cases
        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("add_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
        run_op("add_80_80_c", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

        // Backpressure: result held while out_ready is low; in_valid ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'h12;
        b         = 8'h34;
        cin       = 1'b1;
        tick();                                 // accept -> cycle 1
        in_valid  = 1'b0;
        repeat (8) tick();                      // cycle 9
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.sum", 32'(sum), 32'h47);
            chk("bp.cout", 32'(cout), 32'd0);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            if (i == 1) begin
                in_valid = 1'b1;
                a        = 8'h55;
                b        = 8'h55;
                cin      = 1'b0;
            end
            if (i == 2) begin
                in_valid = 1'b0;
            end
            tick();
        end
        chk("bp.still_valid", 32'(out_valid), 32'd1);
        chk("bp.sum_after", 32'(sum), 32'h47);
        out_ready = 1'b1;
        tick();
        chk("bp.in_ready_back", 32'(in_ready), 32'd1);
        chk("bp.busy_idle", 32'(busy), 32'd0);
        tick();
        chk("bp.no_stale_accept", 32'(busy), 32'd0);

        // Reset in the middle of RUN
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h11;
        cin      = 1'b1;
        tick();                                 // cycle 1
        in_valid = 1'b0;
        repeat (3) tick();                      // cycle 4
        chk("mid.busy_c4", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();                                 // cycle 5
        rst = 1'b0;
        chk("mid.in_ready", 32'(in_ready), 32'd1);
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.sum", 32'(sum), 32'd0);
        run_op("post_rst", 8'h03, 8'h05, 1'b0, 8'h08, 1'b0);

        // W = 1: RUN lasts a single cycle
        in_valid1 = 1'b1;
        a1        = 1'b1;
        b1        = 1'b1;
        cin1      = 1'b1;
        tick();                                 // cycle 1
        in_valid1 = 1'b0;
        chk("w1.busy_c1", 32'(busy1), 32'd1);
        chk("w1.ov_c1", 32'(out_valid1), 32'd0);
        tick();                                 // cycle 2
        chk("w1.ov_c2", 32'(out_valid1), 32'd1);
        chk("w1.sum", 32'(sum1), 32'd1);
        chk("w1.cout", 32'(cout1), 32'd1);
        tick();                                 // cycle 3
        chk("w1.in_ready_c3", 32'(in_ready1), 32'd1);
        in_valid1 = 1'b1;
        a1        = 1'b1;
        b1        = 1'b0;
        cin1      = 1'b0;
        tick();
        in_valid1 = 1'b0;
        tick();
        chk("w1b.sum", 32'(sum1), 32'd1);
        chk("w1b.cout", 32'(cout1), 32'd0);
        tick();

        // Back-to-back random sweep against a+b+cin
        for (int n = 0; n < 24; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            logic [8:0] ref_v;
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            rc    = 1'($urandom_range(0, 1));
            ref_v = 9'(ra) + 9'(rb) + 9'(rc);
            run_op("rand", ra, rb, rc, ref_v[7:0], ref_v[8]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_add_seq
`default_nettype wire

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial multi-bit adder built around a single 1-bit full-adder cell. It accepts two W-bit operands and a carry-in through a valid/ready handshake, then feeds the cell one bit pair per clock, LSB first, with the carry held in a register. After W cycles it presents the W-bit sum and the carry-out on an output handshake. It trades latency for area and sits between operand sources and any consumer of the result.

## Interface
- W, default 8: operand and sum width in bits; legal range ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b and cin are presented.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer takes the result.
- sum  out  W  (a + b + cin) mod 2^W.
- cout  out  1  bit W of a + b + cin.
- busy  out  1  high while in RUN.

## Operation
- The FSM has three states:
  - IDLE: in_ready = 1. When in_valid is high, latch a into shift register SA, b into SB and cin into carry register CY. Clear bit counter CNT, clear the result register SR, go to RUN.
  - RUN: each cycle the cell computes {c, s} = SA[0] + SB[0] + CY.
    - SA and SB shift right one bit.
    - SR shifts right with s entering at bit W-1.
    - CY is updated to c and CNT increments.
    - When CNT = W-1, go to DONE.
  - DONE: out_valid = 1, sum = SR, cout = CY. Hold all values stable until out_ready is high, then go to IDLE.
- CNT width is clog2(W+1). It never wraps during a valid operation.
- in_valid in RUN or DONE is ignored: in_ready is 0, and no operand is latched or dropped silently, because the source must hold its data.
- out_ready outside DONE is ignored.
- For W = 1, RUN lasts exactly one cycle.
- The result is exact modular arithmetic. For example, a = 2^W-1, b = 2^W-1, cin = 1 gives sum = 2^W-1 and cout = 1.

## Timing
- Reset values: in_ready = 1, out_valid = 0, busy = 0, sum = 0, cout = 0, FSM in IDLE, CNT = 0.
- Reset asserted mid-RUN or in DONE aborts the operation on the next edge. No partial result is ever flagged valid.
- Accept edge: the edge where in_valid and in_ready are both high, called cycle 0.
- busy is high on cycles 1..W.
- out_valid first rises on cycle W+1. Latency from accept to out_valid is W+1 edges.
- The transfer completes on the edge with out_valid and out_ready both high. in_ready returns to 1 on the following cycle.
- There is no same-cycle accept while in DONE. Minimum spacing between accepts is W+2 cycles with out_ready held high.
- All outputs are registered. No combinational path runs from in_valid or out_ready to any output.

## Structure
- A shared package holds:
  - the state enum {IDLE, RUN, DONE};
  - a helper function for the counter width (clog2).
- One sub-module is natural: fa_cell, a purely combinational 1-bit full adder.
  - Inputs: x, y, ci.
  - Outputs: s = x^y^ci and co = (x&y)|(ci&(x^y)).
  - One instance is used; the top holds all sequential logic.

## Test plan
- W=8, a=0x0F, b=0x01, cin=0, out_ready=1 -> out_valid on cycle 9 with sum=0x10, cout=0; in_ready back high on cycle 10.
- W=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple). Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready low for 5 cycles in DONE -> sum, cout and out_valid held stable. in_ready stays 0, and an in_valid pulse during this window is not accepted.
- Reset mid-RUN: assert rst on cycle 4 -> next cycle shows in_ready=1, busy=0, out_valid=0, sum=0. A fresh a=0x03, b=0x05 then yields sum=0x08.
- W=1: a=1, b=1, cin=1 -> sum=1, cout=1 on cycle 2. Random back-to-back sweep for W=8 against a reference model of a+b+cin.
